// File: rtl/debounce_pkg.sv
// Shared types and elaboration-time helpers for the multi-button debounce scheduler.
package debounce_pkg;

  typedef enum logic [1:0] {
    LO_STABLE,
    CHK_HI,
    HI_STABLE,
    CHK_LO
  } ch_state_t;

  // Clocks per sample tick, rounded to nearest and never below one.
  function automatic int tick_cycles(input longint clk_freq, input real db_time, input int samples);
    real r;
    int  n;
    r = real'(clk_freq) * db_time / real'(samples);
    n = int'(r);
    return (n < 1) ? 1 : n;
  endfunction

  // $clog2 that still yields a usable 1-bit width for counts of 0 or 1.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchronizer, 4-state debounce FSM advanced by the
// shared sample tick, registered debounced level and one-clock press pulse.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int SAMPLES = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  input  logic tick,
  output logic db_level,
  output logic press
);

  localparam int CNT_W = clog2_min1(SAMPLES);

  logic [1:0]       sync;
  logic             btn_s;
  ch_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             db_nxt, press_nxt;

  assign btn_s = sync[1];

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync     <= '0;
      state    <= LO_STABLE;
      cnt      <= '0;
      db_level <= 1'b0;
      press    <= 1'b0;
    end else begin
      sync     <= {sync[0], btn};
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      db_level <= db_nxt;
      press    <= press_nxt;
    end
  end

  // NOTE: every output of this block gets a default first; a missed branch
  // would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    db_nxt    = db_level;
    press_nxt = 1'b0;
    if (tick) begin
      unique case (state)
        LO_STABLE: if (btn_s) begin
          state_nxt = CHK_HI;
          cnt_nxt   = '0;
        end
        CHK_HI: begin
          if (!btn_s) begin
            state_nxt = LO_STABLE;
          end else if (cnt == CNT_W'(SAMPLES - 1)) begin
            state_nxt = HI_STABLE;
            db_nxt    = 1'b1;
            press_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        HI_STABLE: if (!btn_s) begin
          state_nxt = CHK_LO;
          cnt_nxt   = '0;
        end
        CHK_LO: begin
          if (btn_s) begin
            state_nxt = HI_STABLE;
          end else if (cnt == CNT_W'(SAMPLES - 1)) begin
            state_nxt = LO_STABLE;
            db_nxt    = 1'b0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        default: state_nxt = LO_STABLE;
      endcase
    end
  end

endmodule

// File: rtl/debounce_scheduler.sv
// N_BTN debounce channels sharing one sample-tick prescaler; press events are
// queued per channel and handed out round-robin on a valid/ready port.
module debounce_scheduler
  import debounce_pkg::*;
#(
  parameter int  N_BTN    = 4,
  parameter int  CLK_FREQ = 100_000_000,
  parameter real DB_TIME  = 0.005,
  parameter int  SAMPLES  = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_BTN-1:0]         btn,
  output logic [N_BTN-1:0]         db_level,
  output logic                     evt_valid,
  output logic [$clog2(N_BTN)-1:0] evt_id,
  input  logic                     evt_ready,
  output logic                     overrun
);

  localparam int TICK_CYCLES = tick_cycles(CLK_FREQ, DB_TIME, SAMPLES);
  localparam int PS_W        = clog2_min1(TICK_CYCLES);
  localparam int ID_W        = $clog2(N_BTN);

  logic [PS_W-1:0]  ps;
  logic             tick;
  logic [N_BTN-1:0] press, pending, clr, avail;
  logic [ID_W-1:0]  last_id, base, grant, cand;
  logic             accept, found;

  assign tick = (ps == PS_W'(TICK_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) ps <= '0;
    else       ps <= tick ? '0 : ps + PS_W'(1);
  end

  for (genvar i = 0; i < N_BTN; i++) begin : gen_ch
    debounce_channel #(.SAMPLES(SAMPLES)) u_ch (
      .clk      (clk),
      .reset    (reset),
      .btn      (btn[i]),
      .tick     (tick),
      .db_level (db_level[i]),
      .press    (press[i])
    );
  end

  // The bit being accepted is excluded both from the overrun test and from the
  // next search, so a press coinciding with its own accept is queued, not lost.
  assign accept = evt_valid & evt_ready;
  assign clr    = accept ? ({{(N_BTN-1){1'b0}}, 1'b1} << evt_id) : '0;
  assign avail  = pending & ~clr;
  assign base   = accept ? evt_id : last_id;

  always_comb begin
    found = 1'b0;
    grant = '0;
    cand  = '0;
    for (int k = 1; k <= N_BTN; k++) begin
      cand = ID_W'((int'(base) + k) % N_BTN);
      if (!found && avail[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending   <= '0;
      overrun   <= 1'b0;
      evt_valid <= 1'b0;
      evt_id    <= '0;
      last_id   <= ID_W'(N_BTN - 1);
    end else begin
      pending <= avail | press;
      if (|(press & avail)) overrun <= 1'b1;
      if (accept) last_id <= evt_id;
      if (!evt_valid || accept) begin
        evt_valid <= found;
        if (found) evt_id <= grant;
      end
    end
  end

endmodule

// File: tb/tb_debounce_scheduler.sv
// Directed bench for debounce_scheduler: tick period, glitch rejection, press
// latency, table-driven overrun sequence, round-robin ordering, mid-run reset.
module tb_debounce_scheduler;
  import debounce_pkg::*;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] btn = '0;
  logic         evt_ready = 1'b0;
  logic [N-1:0] db_level;
  logic         evt_valid;
  logic [1:0]   evt_id;
  logic         overrun;

  debounce_scheduler #(
    .N_BTN    (N),
    .CLK_FREQ (100_000_000),
    .DB_TIME  (0.000005),
    .SAMPLES  (10)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn       (btn),
    .db_level  (db_level),
    .evt_valid (evt_valid),
    .evt_id    (evt_id),
    .evt_ready (evt_ready),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_range(input string name, input int actual, input int lo, input int hi);
    n_checks++;
    if (actual < lo || actual > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) step();
    reset = 1'b0;
  endtask

  task automatic wait_db(input int ch, input logic lvl, input int bound, output int n);
    n = 0;
    while (db_level[ch] !== lvl && n < bound) begin
      step();
      n++;
    end
  endtask

  task automatic wait_valid(input int bound, output int n);
    n = 0;
    while (evt_valid !== 1'b1 && n < bound) begin
      step();
      n++;
    end
  endtask

  // Handshake monitor samples late in the low phase, when inputs and outputs are settled.
  int cyc = 0;
  int valid_cnt = 0;
  int acc_id_q[$];
  int acc_cyc_q[$];
  always begin
    @(negedge clk);
    #3;
    cyc++;
    if (!reset && evt_valid === 1'b1) begin
      valid_cnt++;
      if (evt_ready) begin
        acc_id_q.push_back(int'(evt_id));
        acc_cyc_q.push_back(cyc);
      end
    end
  end

  typedef struct {
    logic [N-1:0] btn;
    logic         ready;
    int           cycles;
    logic [N-1:0] db;
    logic         valid;
    int           id;
    logic         ovr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, v0, bad, saw_db;
    int tick_at[$];

    // Overrun sequence on ch3 with ready low, then a clean ch2 press.
    vecs[0] = '{4'b0000, 1'b1,  50, 4'b0000, 1'b0, 0, 1'b0};
    vecs[1] = '{4'b1000, 1'b0, 600, 4'b1000, 1'b1, 3, 1'b0};
    vecs[2] = '{4'b0000, 1'b0, 600, 4'b0000, 1'b1, 3, 1'b0};
    vecs[3] = '{4'b1000, 1'b0, 600, 4'b1000, 1'b1, 3, 1'b1};
    vecs[4] = '{4'b1000, 1'b1,  20, 4'b1000, 1'b0, 0, 1'b1};
    vecs[5] = '{4'b0000, 1'b1, 600, 4'b0000, 1'b0, 0, 1'b1};
    vecs[6] = '{4'b0100, 1'b1, 600, 4'b0100, 1'b0, 0, 1'b1};
    vecs[7] = '{4'b0000, 1'b1, 600, 4'b0000, 1'b0, 0, 1'b1};

    do_reset(3);
    check("rst_db_level", db_level, 0);
    check("rst_evt_valid", evt_valid, 0);
    check("rst_evt_id", evt_id, 0);
    check("rst_overrun", overrun, 0);
    check("rst_pending", dut.pending, 0);

    // Tick is high during cycle 50, 100, 150 after reset release.
    for (int k = 1; k <= 160; k++) begin
      step();
      if (dut.tick) tick_at.push_back(k);
    end
    check("tick_count", tick_at.size(), 3);
    check("tick_first", tick_at[0], 49);
    check("tick_second", tick_at[1], 99);
    check("tick_third", tick_at[2], 149);

    // Glitch train: 40 clocks of 20 ns toggling, shorter than one tick period.
    v0 = valid_cnt;
    saw_db = 0;
    for (int k = 0; k < 20; k++) begin
      btn[0] = ~btn[0];
      repeat (2) begin
        step();
        if (db_level[0]) saw_db = 1;
      end
    end
    repeat (700) begin
      step();
      if (db_level[0]) saw_db = 1;
    end
    check("glitch_db_level", saw_db, 0);
    check("glitch_no_event", valid_cnt - v0, 0);

    // Clean press on ch1, consumer ready.
    evt_ready = 1'b1;
    acc_id_q.delete();
    acc_cyc_q.delete();
    btn[1] = 1'b1;
    wait_db(1, 1'b1, 700, n);
    check_range("press_latency", n, 500, 556);
    repeat (5) step();
    check("press_evt_count", acc_id_q.size(), 1);
    check("press_evt_id", acc_id_q[0], 1);
    v0 = valid_cnt;
    btn[1] = 1'b0;
    wait_db(1, 1'b0, 700, n);
    check_range("release_latency", n, 500, 556);
    repeat (5) step();
    check("release_no_event", valid_cnt - v0, 0);

    acc_id_q.delete();
    acc_cyc_q.delete();
    foreach (vecs[i]) begin
      btn = vecs[i].btn;
      evt_ready = vecs[i].ready;
      repeat (vecs[i].cycles) step();
      check($sformatf("vec%0d_db_level", i), db_level, vecs[i].db);
      check($sformatf("vec%0d_evt_valid", i), evt_valid, vecs[i].valid);
      if (vecs[i].valid) check($sformatf("vec%0d_evt_id", i), evt_id, vecs[i].id);
      check($sformatf("vec%0d_overrun", i), overrun, vecs[i].ovr);
    end
    check("vec_accept_count", acc_id_q.size(), 2);
    check("vec_accept_0", acc_id_q[0], 3);
    check("vec_accept_1", acc_id_q[1], 2);

    do_reset(3);
    check("rst2_overrun", overrun, 0);
    check("rst2_evt_valid", evt_valid, 0);

    // Simultaneous ch0/ch2 presses, ready high: back-to-back ids 0 then 2.
    acc_id_q.delete();
    acc_cyc_q.delete();
    evt_ready = 1'b1;
    btn = 4'b0101;
    n = 0;
    while (acc_id_q.size() < 2 && n < 700) begin
      step();
      n++;
    end
    check("rr1_count", acc_id_q.size(), 2);
    check("rr1_first", acc_id_q[0], 0);
    check("rr1_second", acc_id_q[1], 2);
    check("rr1_consecutive", acc_cyc_q[1] - acc_cyc_q[0], 1);
    btn = '0;
    repeat (600) step();

    // Same presses, ready low: grant follows last_id=2, so ch0 first, held stable.
    evt_ready = 1'b0;
    acc_id_q.delete();
    acc_cyc_q.delete();
    btn = 4'b0101;
    wait_valid(700, n);
    check("rr2_valid", evt_valid, 1);
    check("rr2_first_grant", evt_id, 0);
    bad = 0;
    repeat (20) begin
      step();
      if (evt_valid !== 1'b1 || evt_id !== 2'd0) bad++;
    end
    check("rr2_hold_stable", bad, 0);
    check("rr2_no_accept", acc_id_q.size(), 0);
    evt_ready = 1'b1;
    repeat (5) step();
    check("rr2_count", acc_id_q.size(), 2);
    check("rr2_first", acc_id_q[0], 0);
    check("rr2_second", acc_id_q[1], 2);
    check("rr2_consecutive", acc_cyc_q[1] - acc_cyc_q[0], 1);
    btn = '0;
    repeat (600) step();

    // Reset while a ch1 event waits and ch2 is mid-debounce.
    evt_ready = 1'b0;
    btn = 4'b0010;
    wait_valid(700, n);
    check("mid_evt_valid", evt_valid, 1);
    check("mid_evt_id", evt_id, 1);
    btn = 4'b0110;
    repeat (200) step();
    check("mid_ch2_debouncing", db_level[2], 0);
    do_reset(1);
    check("mid_rst_db_level", db_level, 0);
    check("mid_rst_evt_valid", evt_valid, 0);
    check("mid_rst_evt_id", evt_id, 0);
    check("mid_rst_overrun", overrun, 0);
    check("mid_rst_pending", dut.pending, 0);
    wait_db(2, 1'b1, 700, n);
    check("mid_redebounce_latency", n, 550);
    repeat (3) step();
    check("mid_post_valid", evt_valid, 1);
    check("mid_post_id", evt_id, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
